// File: rtl/mem_rmw_seq_if.sv
// Memory bus between the read-modify-write sequencer (master) and memory (slave).
// Word-addressed, single outstanding request, held until ack.
interface mem_rmw_seq_if;
   localparam int unsigned ADDR_W = 30;
   localparam int unsigned DATA_W = 64;

   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [DATA_W-1:0] bus_rdata;
   logic              bus_ack;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata,
      input  bus_rdata, bus_ack
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata,
      output bus_rdata, bus_ack
   );
endinterface

// File: rtl/mem_rmw_seq.sv
// Load/store sequencer: reads a memory word, lets the LSU extract or merge,
// then returns load data or writes the merged word back. Bus stalls time out.
module mem_rmw_seq #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  func,
   input  logic [29:0] lsu_addr,
   input  logic [63:0] lsu_mem_out,
   input  logic [31:0] lsu_reg_out,
   output logic [63:0] lsu_mem_in,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic [31:0] load_data,
   mem_rmw_seq_if.master bus
);
   localparam int unsigned WAIT_W = 8;

   typedef enum logic [2:0] {IDLE, READ, CALC, WRITE, DONE} state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q;
   logic              store_q;
   logic              fault_d;
   logic              req_d, we_d, busy_d, done_d;
   logic              func_ok_c;
   logic              timeout_c;

   always_comb begin
      func_ok_c = 1'b0;
      case (func)
         4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
         4'b1000, 4'b1001, 4'b1010: func_ok_c = 1'b1;
         default:                   func_ok_c = 1'b0;
      endcase
   end

   // Timeout fires on the cycle the wait count would reach MAX_WAIT.
   assign timeout_c = !bus.bus_ack && (wait_q == WAIT_W'(MAX_WAIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      fault_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (func_ok_c) begin
                  state_d = READ;
               end else begin
                  state_d = DONE;
                  fault_d = 1'b1;
               end
            end
         end
         READ: begin
            if (bus.bus_ack) begin
               state_d = CALC;
            end else if (timeout_c) begin
               state_d = DONE;
               fault_d = 1'b1;
            end
         end
         CALC:  state_d = store_q ? WRITE : DONE;
         WRITE: begin
            if (bus.bus_ack) begin
               state_d = DONE;
            end else if (timeout_c) begin
               state_d = DONE;
               fault_d = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered status/bus-control outputs.
   always_comb begin
      req_d  = (state_d == READ) || (state_d == WRITE);
      we_d   = (state_d == WRITE);
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.bus_req   <= 1'b0;
         bus.bus_we    <= 1'b0;
         bus.bus_addr  <= '0;
         bus.bus_wdata <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         fault         <= 1'b0;
         lsu_mem_in    <= '0;
         load_data     <= '0;
         wait_q        <= '0;
         store_q       <= 1'b0;
      end else begin
         bus.bus_req <= req_d;
         bus.bus_we  <= we_d;
         busy        <= busy_d;
         done        <= done_d;
         fault       <= fault_d;

         if (state_d != state_q) begin
            wait_q <= '0;
         end else if (((state_q == READ) || (state_q == WRITE)) && !bus.bus_ack) begin
            wait_q <= wait_q + WAIT_W'(1);
         end

         if ((state_q == IDLE) && start && func_ok_c) begin
            bus.bus_addr <= lsu_addr;
            store_q      <= func[3];
         end

         if ((state_q == READ) && bus.bus_ack) begin
            lsu_mem_in <= bus.bus_rdata;
         end

         if (state_q == CALC) begin
            if (store_q) bus.bus_wdata <= lsu_mem_out;
            else         load_data     <= lsu_reg_out;
         end
      end
   end
endmodule

// File: tb/tb_mem_rmw_seq.sv
// Randomized bench for mem_rmw_seq: a per-transaction timeline model predicts
// every cycle of bus/status activity; a few directed cases pin literal values.
module tb_mem_rmw_seq;
   localparam int unsigned MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  func = 4'b0;
   logic [29:0] lsu_addr = '0;
   logic [31:0] sdata = '0;
   logic [63:0] lsu_mem_out;
   logic [31:0] lsu_reg_out;
   logic [63:0] lsu_mem_in;
   logic        busy, done, fault;
   logic [31:0] load_data;
   logic        start_hold = 1'b0;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_ld = '0;

   int          obs_done, obs_req, obs_ndone;
   logic        obs_fault;
   logic [63:0] obs_wdata;
   logic [31:0] obs_load;

   mem_rmw_seq_if bus_if ();

   mem_rmw_seq #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .func        (func),
      .lsu_addr    (lsu_addr),
      .lsu_mem_out (lsu_mem_out),
      .lsu_reg_out (lsu_reg_out),
      .lsu_mem_in  (lsu_mem_in),
      .busy        (busy),
      .done        (done),
      .fault       (fault),
      .load_data   (load_data),
      .bus         (bus_if)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] lsu_load(input logic [3:0] f, input logic [63:0] m);
      case (f)
         4'b0000: return {{24{m[7]}}, m[7:0]};
         4'b0001: return {{16{m[15]}}, m[15:0]};
         4'b0100: return {24'h0, m[7:0]};
         4'b0101: return {16'h0, m[15:0]};
         default: return m[31:0];
      endcase
   endfunction

   function automatic logic [63:0] lsu_store(input logic [3:0] f, input logic [63:0] m,
                                             input logic [31:0] sd);
      case (f)
         4'b1000: return {m[63:8], sd[7:0]};
         4'b1001: return {m[63:16], sd[15:0]};
         4'b1010: return {m[63:32], sd};
         default: return m;
      endcase
   endfunction

   function automatic bit valid_f(input logic [3:0] f);
      return f inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
                       4'b1000, 4'b1001, 4'b1010};
   endfunction

   // LSU stand-in, byte index 0, driven by the held request.
   assign lsu_reg_out = lsu_load(func, lsu_mem_in);
   assign lsu_mem_out = lsu_store(func, lsu_mem_in, sdata);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Issue one request and check every cycle until one cycle past done.
   // d1/d2 are read/write ack delays; a delay >= MAX_WAIT means no ack at all.
   task automatic run_txn(input logic [3:0] f, input logic [29:0] a, input logic [63:0] rd,
                          input logic [31:0] sd, input int d1, input int d2);
      int          r, w, dc;
      bit          v, st, rto, wto, expf;
      logic [63:0] exp_wd;
      logic [31:0] exp_ld;
      v   = valid_f(f);
      st  = f[3];
      rto = (d1 >= int'(MAX_WAIT));
      wto = (d2 >= int'(MAX_WAIT));
      r   = rto ? int'(MAX_WAIT) : d1 + 1;
      w   = wto ? int'(MAX_WAIT) : d2 + 1;
      if (!v)       dc = 1;
      else if (rto) dc = r + 1;
      else if (!st) dc = r + 2;
      else          dc = r + w + 2;
      expf   = !v || rto || (st && wto);
      exp_wd = lsu_store(f, rd, sd);
      exp_ld = (v && !rto && !st) ? lsu_load(f, rd) : model_ld;
      obs_done = -1; obs_req = 0; obs_ndone = 0; obs_fault = 1'b0;
      obs_wdata = '0; obs_load = '0;

      func = f; lsu_addr = a; sdata = sd; start = 1'b1;
      bus_if.bus_rdata = rd;
      bus_if.bus_ack   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      for (int k = 1; k <= dc + 1; k++) begin
         bit in_rd, in_wr, ack;
         in_rd = v && (k <= r);
         in_wr = v && st && !rto && (k >= r + 2) && (k <= r + 1 + w);
         if (in_rd)      ack = !rto && (k == r);
         else if (in_wr) ack = !wto && (k == r + 1 + w);
         else            ack = 1'($urandom_range(0, 1));
         bus_if.bus_ack   = ack;
         bus_if.bus_rdata = (in_rd && ack) ? rd : {$urandom, $urandom};
         start = (k <= dc) ? (start_hold | 1'($urandom_range(0, 1))) : 1'b0;

         chk("bus_req", 64'(bus_if.bus_req), 64'(in_rd || in_wr));
         chk("bus_we", 64'(bus_if.bus_we), 64'(in_wr));
         chk("busy", 64'(busy), 64'(k <= dc));
         chk("done", 64'(done), 64'(k == dc));
         if (in_rd || in_wr) chk("bus_addr", 64'(bus_if.bus_addr), 64'(a));
         if (in_wr) chk("bus_wdata", bus_if.bus_wdata, exp_wd);
         if (k == dc) begin
            chk("fault", 64'(fault), 64'(expf));
            chk("load_data", 64'(load_data), 64'(exp_ld));
            if (v && !rto) chk("lsu_mem_in", lsu_mem_in, rd);
            obs_fault = fault; obs_wdata = bus_if.bus_wdata; obs_load = load_data;
         end
         if (bus_if.bus_req) obs_req++;
         if (done) begin
            obs_ndone++;
            if (obs_done < 0) obs_done = k;
         end
         @(posedge clk); #1;
      end
      model_ld = exp_ld;
   endtask

   initial begin
      logic [3:0] fl [8];
      logic [3:0] f;
      int         d1, d2;
      fl = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1010};
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_rdata = '0;
      #1;
      chk("rst_bus_req", 64'(bus_if.bus_req), 64'd0);
      chk("rst_bus_we", 64'(bus_if.bus_we), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_fault", 64'(fault), 64'd0);
      chk("rst_load_data", 64'(load_data), 64'd0);
      chk("rst_lsu_mem_in", lsu_mem_in, 64'd0);
      chk("rst_bus_addr", 64'(bus_if.bus_addr), 64'd0);
      chk("rst_bus_wdata", bus_if.bus_wdata, 64'd0);
      #11 rst_n = 1'b1;
      @(posedge clk); #1;

      // lb, sign-extended byte 0x80, immediate ack
      run_txn(4'b0000, 30'h4, 64'h80, 32'h0, 0, 0);
      chk("lb_done_cycle", 64'(obs_done), 64'd3);
      chk("lb_load_data", 64'(obs_load), 64'hFFFF_FF80);
      chk("lb_fault", 64'(obs_fault), 64'd0);

      // sw with 2-cycle ack delay on both bus phases
      run_txn(4'b1010, 30'h10, 64'h1122_3344_0000_0000, 32'hDEAD_BEEF, 2, 2);
      chk("sw_done_cycle", 64'(obs_done), 64'd8);
      chk("sw_wdata", obs_wdata, 64'h1122_3344_DEAD_BEEF);
      chk("sw_bus_cycles", 64'(obs_req), 64'd6);

      // illegal func
      run_txn(4'b0011, 30'h7, 64'h1234, 32'h0, 0, 0);
      chk("bad_done_cycle", 64'(obs_done), 64'd1);
      chk("bad_bus_req", 64'(obs_req), 64'd0);
      chk("bad_fault", 64'(obs_fault), 64'd1);
      chk("bad_load_data", 64'(obs_load), 64'hFFFF_FF80);

      // read timeout
      run_txn(4'b0010, 30'h8, 64'h5555, 32'h0, 9, 0);
      chk("to_req_cycles", 64'(obs_req), 64'd4);
      chk("to_done_cycle", 64'(obs_done), 64'd5);
      chk("to_fault", 64'(obs_fault), 64'd1);
      chk("to_load_data", 64'(obs_load), 64'hFFFF_FF80);

      // start held high through a whole load
      start_hold = 1'b1;
      run_txn(4'b0010, 30'h9, 64'hCAFE_F00D_8765_4321, 32'h0, 1, 0);
      start_hold = 1'b0;
      chk("hold_done_pulses", 64'(obs_ndone), 64'd1);
      chk("hold_load_data", 64'(obs_load), 64'h8765_4321);

      // reset asserted mid-WRITE
      func = 4'b1010; lsu_addr = 30'h2A; sdata = 32'h55AA_55AA;
      bus_if.bus_rdata = 64'h0; bus_if.bus_ack = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; bus_if.bus_ack = 1'b1;
      @(posedge clk); #1;
      bus_if.bus_ack = 1'b0;
      @(posedge clk); #1;
      chk("pre_rst_we", 64'(bus_if.bus_we), 64'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_req", 64'(bus_if.bus_req), 64'd0);
      chk("async_rst_we", 64'(bus_if.bus_we), 64'd0);
      chk("async_rst_busy", 64'(busy), 64'd0);
      chk("async_rst_addr", 64'(bus_if.bus_addr), 64'd0);
      chk("async_rst_wdata", bus_if.bus_wdata, 64'd0);
      rst_n = 1'b1;
      bus_if.bus_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("post_rst_req", 64'(bus_if.bus_req), 64'd0);
         chk("post_rst_busy", 64'(busy), 64'd0);
      end
      model_ld = '0;
      run_txn(4'b0010, 30'h3, 64'h0000_0001_ABCD_0123, 32'h0, 0, 0);
      chk("post_rst_lw", 64'(obs_load), 64'hABCD_0123);
      chk("post_rst_lw_done", 64'(obs_done), 64'd3);

      // randomized mix, including bad funcs and timeouts on either phase
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 9) < 8) begin
            f = fl[$urandom_range(0, 7)];
         end else begin
            f = 4'($urandom);
            if (valid_f(f)) f = 4'b1111;
         end
         d1 = ($urandom_range(0, 5) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 2));
         d2 = ($urandom_range(0, 5) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 2));
         run_txn(f, 30'($urandom), {$urandom, $urandom}, $urandom, d1, d2);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
